// File: rtl/uart_mem_cmd_engine.sv
// Byte-stream command engine: decodes READ / WRITE / FILL / CHECKSUM frames
// arriving from the UART receiver, executes them against an internal byte
// memory and streams replies back through the UART transmitter.
module uart_mem_cmd_engine #(
  parameter int          ADDR_BYTES     = 2,
  parameter int          MEM_DEPTH      = 4096,
  parameter int          TIMEOUT_CYCLES = 1200000,
  parameter logic [7:0]  ACK_BYTE       = 8'hAA
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       received,
  input  logic [7:0] rx_byte,
  input  logic       is_transmitting,
  output logic       transmit,
  output logic [7:0] tx_byte,
  output logic       busy,
  output logic       timeout,
  output logic [7:0] overrun_count
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [3:0] {
    IDLE, RX_CNT, RX_ADDR, RX_DATA, RD_ISSUE, RD_SEND, TX_HOLD, TX_WAIT,
    FILL_RUN, SUM, SUM_SEND, ACK
  } state_t;

  // Command byte minus one, so 01..04 map onto the two-bit code directly.
  typedef enum logic [1:0] {CMD_READ, CMD_WRITE, CMD_FILL, CMD_SUM} cmd_t;

  state_t         state, state_nx;
  cmd_t           cmd;
  logic [8:0]     left;        // bytes still to transfer for this command
  logic [AW-1:0]  addr;
  logic [1:0]     abyte;       // address bytes collected so far
  logic [7:0]     sum;
  logic [7:0]     fill_byte;
  logic           sum_vld;     // a checksum read is returning this cycle
  logic [TW-1:0]  timer;
  logic [7:0]     mem [MEM_DEPTH];
  logic [7:0]     mem_rdata;
  logic           mem_we, mem_re;
  logic [7:0]     mem_wdata;
  logic           rx_phase;

  assign rx_phase = (state == RX_CNT) || (state == RX_ADDR) || (state == RX_DATA);
  assign busy     = (state != IDLE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state decode plus the transmit strobe, memory port controls and timeout.
  always_comb begin
    // NOTE: every output of this block gets a default here so no path leaves one unassigned, which would infer a latch.
    state_nx  = state;
    transmit  = 1'b0;
    tx_byte   = 8'h00;
    timeout   = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_wdata = 8'h00;
    case (state)
      IDLE:     if (received && (rx_byte inside {[8'd1:8'd4]})) state_nx = RX_CNT;
      RX_CNT:   if (received) state_nx = RX_ADDR;
      RX_ADDR:
        if (received && abyte == 2'(ADDR_BYTES - 1)) begin
          case (cmd)
            CMD_READ: state_nx = RD_ISSUE;
            CMD_SUM:  state_nx = SUM;
            default:  state_nx = RX_DATA;
          endcase
        end
      RX_DATA:
        if (received) begin
          if (cmd == CMD_FILL) begin
            state_nx = FILL_RUN;
          end else begin
            mem_we    = 1'b1;
            mem_wdata = rx_byte;
            if (left == 9'd1) state_nx = ACK;
          end
        end
      RD_ISSUE:
        if (!is_transmitting) begin
          mem_re   = 1'b1;
          state_nx = RD_SEND;
        end
      RD_SEND: begin
        transmit = 1'b1;
        tx_byte  = mem_rdata;
        state_nx = TX_HOLD;
      end
      // One unconditional clock lets the UART raise is_transmitting.
      TX_HOLD:  state_nx = TX_WAIT;
      TX_WAIT:  if (!is_transmitting) state_nx = (left == 9'd0) ? IDLE : RD_ISSUE;
      FILL_RUN: begin
        mem_we    = 1'b1;
        mem_wdata = fill_byte;
        if (left == 9'd1) state_nx = ACK;
      end
      SUM: begin
        mem_re = (left != 9'd0);
        if (left == 9'd0 && sum_vld) state_nx = SUM_SEND;
      end
      SUM_SEND:
        if (!is_transmitting) begin
          transmit = 1'b1;
          tx_byte  = sum;
          state_nx = TX_HOLD;
        end
      ACK:
        if (!is_transmitting) begin
          transmit = 1'b1;
          tx_byte  = ACK_BYTE;
          state_nx = TX_HOLD;
        end
      default:  state_nx = IDLE;
    endcase
    // A strobe in the expiry cycle wins: the counter restarts instead.
    if (rx_phase && !received && timer == TW'(TIMEOUT_CYCLES - 1)) begin
      timeout  = 1'b1;
      state_nx = IDLE;
    end
  end

  // Command context: count, address, checksum, inter-byte timer, overrun counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd           <= CMD_READ;
      left          <= '0;
      addr          <= '0;
      abyte         <= '0;
      sum           <= '0;
      fill_byte     <= '0;
      sum_vld       <= 1'b0;
      timer         <= '0;
      overrun_count <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      timer   <= (rx_phase && !received) ? timer + 1'b1 : '0;
      sum_vld <= (state == SUM) && (left != 9'd0);
      if (received && !rx_phase && state != IDLE && overrun_count != 8'hFF)
        overrun_count <= overrun_count + 8'd1;
      case (state)
        IDLE:
          if (state_nx == RX_CNT) begin
            cmd   <= cmd_t'(rx_byte[1:0] - 2'd1);
            sum   <= '0;
            abyte <= '0;
            addr  <= '0;
          end
        RX_CNT:  if (received) left <= {1'b0, rx_byte} + 9'd1;
        // Shifting MSB-first and keeping the low AW bits discards the high address bits.
        RX_ADDR:
          if (received) begin
            addr  <= AW'({addr, rx_byte});
            abyte <= abyte + 2'd1;
          end
        RX_DATA:
          if (received && state_nx != IDLE) begin
            if (cmd == CMD_FILL) begin
              fill_byte <= rx_byte;
            end else begin
              addr <= addr + 1'b1;
              left <= left - 9'd1;
            end
          end
        RD_ISSUE:
          if (mem_re) begin
            addr <= addr + 1'b1;
            left <= left - 9'd1;
          end
        FILL_RUN: begin
          addr <= addr + 1'b1;
          left <= left - 9'd1;
        end
        SUM: begin
          if (left != 9'd0) begin
            addr <= addr + 1'b1;
            left <= left - 9'd1;
          end
          if (sum_vld) sum <= sum + mem_rdata;
        end
        default: ;
      endcase
    end
  end

  // Byte memory: one write per clock, registered read with one cycle of latency.
  always_ff @(posedge clk) begin
    // NOTE: the memory array has no reset; contents survive rst and only control state is cleared.
    if (mem_we) mem[addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[addr];
  end

endmodule

// File: tb/tb_uart_mem_cmd_engine.sv
// Self-checking bench for uart_mem_cmd_engine: a table of command frames with
// hand-computed replies, plus directed sequences for timeout, first-byte
// latency, 256-byte transfers with overrun strobes and reset mid-read.
module tb_uart_mem_cmd_engine;

  logic       clk = 1'b0;
  logic       rst, received, is_transmitting, transmit, busy, timeout;
  logic [7:0] rx_byte, tx_byte, overrun_count;

  int checks = 0;
  int errors = 0;

  logic [7:0] tx_q[$];
  int         to_cnt      = 0;
  int         tx_overlap  = 0;
  int         tx_wait_cnt = 0;
  int         tx_busy_left = 0;

  typedef struct packed {
    logic [3:0]  n_in;
    logic [63:0] in_b;   // bytes left-aligned, first byte in [63:56]
    logic [2:0]  n_out;
    logic [31:0] out_b;  // expected replies left-aligned
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  uart_mem_cmd_engine #(
    .ADDR_BYTES    (2),
    .MEM_DEPTH     (4096),
    .TIMEOUT_CYCLES(50),
    .ACK_BYTE      (8'hAA)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .received       (received),
    .rx_byte        (rx_byte),
    .is_transmitting(is_transmitting),
    .transmit       (transmit),
    .tx_byte        (tx_byte),
    .busy           (busy),
    .timeout        (timeout),
    .overrun_count  (overrun_count)
  );

  initial forever #5 clk = ~clk;

  // UART transmitter model: busy rises two clocks after a transmit strobe, for three clocks.
  initial begin
    is_transmitting = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tx_busy_left > 0) tx_busy_left--;
      if (tx_wait_cnt > 0) begin
        tx_wait_cnt--;
        if (tx_wait_cnt == 0) tx_busy_left = 3;
      end
      is_transmitting = (tx_busy_left != 0);
    end
  end

  // Output monitor, sampled mid-cycle.
  initial forever begin
    @(negedge clk);
    if (transmit) begin
      tx_q.push_back(tx_byte);
      if (is_transmitting) tx_overlap++;
      tx_wait_cnt = 2;
    end
    if (timeout) to_cnt++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 7 + 3) & 255);
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    received = 1'b1;
    rx_byte  = b;
    @(posedge clk); #1;
    received = 1'b0;
    @(posedge clk);
  endtask

  task automatic wait_idle(input string name);
    int c;
    c = 0;
    while (busy && c < 5000) begin
      @(negedge clk);
      c++;
    end
    check({name, " idle"}, {31'd0, busy}, 32'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, input int id);
    string nm;
    nm = $sformatf("vec%0d", id);
    tx_q.delete();
    for (int i = 0; i < int'(v.n_in); i++) send_byte(v.in_b[63 - 8 * i -: 8]);
    wait_idle(nm);
    check({nm, " count"}, tx_q.size(), {29'd0, v.n_out});
    for (int j = 0; j < int'(v.n_out) && j < tx_q.size(); j++)
      check($sformatf("%s byte%0d", nm, j), {24'd0, tx_q[j]}, {24'd0, v.out_b[31 - 8 * j -: 8]});
  endtask

  initial begin
    int first, pulses, b49, b51, to_base, inj, bad, seen;
    logic [7:0] s;

    vecs[0]  = '{4'd7, 64'h0202_0010_AABB_CC00, 3'd1, 32'hAA00_0000};  // WRITE
    vecs[1]  = '{4'd4, 64'h0102_0010_0000_0000, 3'd3, 32'hAABB_CC00};  // READ
    vecs[2]  = '{4'd4, 64'h0401_0010_0000_0000, 3'd1, 32'h6500_0000};  // CHECKSUM
    vecs[3]  = '{4'd5, 64'h0303_0FFE_5A00_0000, 3'd1, 32'hAA00_0000};  // FILL wraps
    vecs[4]  = '{4'd4, 64'h0103_0FFE_0000_0000, 3'd4, 32'h5A5A_5A5A};
    vecs[5]  = '{4'd4, 64'h0403_0FFE_0000_0000, 3'd1, 32'h6800_0000};
    vecs[6]  = '{4'd7, 64'h0005_FF01_0000_1000, 3'd1, 32'hAA00_0000};  // junk then READ
    vecs[7]  = '{4'd4, 64'h0100_F011_0000_0000, 3'd1, 32'hBB00_0000};  // high addr bits dropped
    vecs[8]  = '{4'd6, 64'h0201_0FFF_1122_0000, 3'd1, 32'hAA00_0000};  // WRITE wraps
    vecs[9]  = '{4'd4, 64'h0101_0FFF_0000_0000, 3'd2, 32'h1122_0000};
    vecs[10] = '{4'd4, 64'h0402_0FFE_0000_0000, 3'd1, 32'h8D00_0000};

    rst      = 1'b1;
    received = 1'b0;
    rx_byte  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst transmit", {31'd0, transmit}, 32'd0);
    check("rst tx_byte", {24'd0, tx_byte}, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst timeout", {31'd0, timeout}, 32'd0);
    check("rst overrun", {24'd0, overrun_count}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int v = 0; v < NV; v++) run_vec(vecs[v], v);
    check("table timeouts", to_cnt, 0);

    // Timeout: WRITE header then silence; expiry on the 50th idle clock.
    tx_q.delete();
    to_base = to_cnt;
    send_byte(8'h02);
    @(posedge clk); #1; received = 1'b1; rx_byte = 8'h00;
    @(posedge clk); #1; received = 1'b0;
    first = 0; pulses = 0; b49 = 0; b51 = 1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (timeout) begin
        pulses++;
        if (first == 0) first = k;
      end
      if (k == 49) b49 = int'(busy);
      if (k == 51) b51 = int'(busy);
    end
    check("timeout cycle", first, 50);
    check("timeout pulses", pulses, 1);
    check("timeout busy before", b49, 1);
    check("timeout busy after", b51, 0);
    check("timeout no tx", tx_q.size(), 0);

    // READ after timeout; first transmit exactly two clocks after the last address strobe.
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
    @(posedge clk); #1; received = 1'b1; rx_byte = 8'h10;
    @(negedge clk);
    @(posedge clk); #1; received = 1'b0;
    @(negedge clk);
    check("latency c1 transmit", {31'd0, transmit}, 32'd0);
    @(negedge clk);
    check("latency c2 transmit", {31'd0, transmit}, 32'd1);
    check("latency c2 tx_byte", {24'd0, tx_byte}, 32'hAA);
    wait_idle("read after timeout");
    check("read after timeout count", tx_q.size(), 1);

    // A strobe landing on the expiry clock wins over the timeout.
    tx_q.delete();
    to_base = to_cnt;
    send_byte(8'h02);
    @(posedge clk); #1; received = 1'b1; rx_byte = 8'h00;
    @(posedge clk); #1; received = 1'b0;
    repeat (49) @(posedge clk);
    #1; received = 1'b1; rx_byte = 8'h00;
    @(negedge clk);
    check("strobe wins no timeout", {31'd0, timeout}, 32'd0);
    @(posedge clk); #1; received = 1'b0;
    send_byte(8'h20);
    send_byte(8'h77);
    wait_idle("strobe wins");
    check("strobe wins timeouts", to_cnt - to_base, 0);
    check("strobe wins ack count", tx_q.size(), 1);
    if (tx_q.size() > 0) check("strobe wins ack", {24'd0, tx_q[0]}, 32'hAA);
    run_vec('{4'd4, 64'h0100_0020_0000_0000, 3'd1, 32'h7700_0000}, 20);

    // 256-byte WRITE of a pattern, then 256-byte READ with three dropped strobes.
    tx_q.delete();
    send_byte(8'h02); send_byte(8'hFF); send_byte(8'h00); send_byte(8'h00);
    for (int i = 0; i < 256; i++) send_byte(pat(i));
    wait_idle("wr256");
    check("wr256 ack count", tx_q.size(), 1);

    tx_q.delete();
    send_byte(8'h01); send_byte(8'hFF); send_byte(8'h00); send_byte(8'h00);
    inj = 0;
    for (int c = 0; c < 20000 && busy; c++) begin
      @(posedge clk); #1;
      if (received) received = 1'b0;
      else if (inj < 3 && tx_q.size() >= 20 + 80 * inj) begin
        received = 1'b1;
        rx_byte  = 8'h01;
        inj++;
      end
    end
    received = 1'b0;
    wait_idle("rd256");
    check("rd256 count", tx_q.size(), 256);
    bad = 0;
    for (int i = 0; i < 256 && i < tx_q.size(); i++) if (tx_q[i] !== pat(i)) bad++;
    check("rd256 data mismatches", bad, 0);
    check("rd256 overrun_count", {24'd0, overrun_count}, 32'd3);

    s = 8'h00;
    for (int i = 0; i < 256; i++) s = s + pat(i);
    run_vec('{4'd4, 64'h04FF_0000_0000_0000, 3'd1, {s, 24'd0}}, 21);
    check("tx never overlaps busy uart", tx_overlap, 0);

    // Reset while the second byte of a 4-byte READ is being transmitted.
    send_byte(8'h01); send_byte(8'h03); send_byte(8'h00); send_byte(8'h40);
    seen = 0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (transmit) begin
        seen++;
        if (seen == 2) break;
      end
    end
    check("reset test reached 2nd byte", seen, 2);
    rst = 1'b1;
    #1;
    check("mid rst transmit", {31'd0, transmit}, 32'd0);
    check("mid rst busy", {31'd0, busy}, 32'd0);
    check("mid rst tx_byte", {24'd0, tx_byte}, 32'd0);
    check("mid rst overrun", {24'd0, overrun_count}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    run_vec('{4'd4, 64'h0100_0040_0000_0000, 3'd1, {pat(64), 24'd0}}, 22);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_mem_cmd_engine.md
Name: uart_mem_cmd_engine

Overview:
Byte-stream command engine between the UART receiver/transmitter and an internal byte memory. It extends the READ/WRITE host protocol with FILL and CHECKSUM commands, ACK replies, and a receive timeout. It also adds overrun counting, parametrised address bytes and parametrised memory depth. It sits between `uart` and the host-side debug tooling in the top level.

Parameters:
ADDR_BYTES, 2, number of big-endian address bytes after the count byte (1..3).
MEM_DEPTH, 4096, memory size in bytes; power of two; address is taken modulo MEM_DEPTH.
TIMEOUT_CYCLES, 1200000, idle clocks allowed between bytes of one command (100 ms at 12 MHz); must be at least 2.
ACK_BYTE, 8'hAA, reply sent after WRITE and FILL complete.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
received  in  1  one-cycle strobe: rx_byte valid
rx_byte  in  8  received byte
is_transmitting  in  1  high while UART is sending
transmit  out  1  one-cycle strobe: send tx_byte
tx_byte  out  8  byte to send, valid when transmit=1
busy  out  1  high in any state other than IDLE
timeout  out  1  one-cycle strobe: command aborted by timeout
overrun_count  out  8  saturating count of bytes dropped while executing

Behaviour:
- Reset (async, any state): state=IDLE, transmit=0, tx_byte=0, busy=0, timeout=0, overrun_count=0, internal count/addr/sum=0. Memory contents are not cleared.
- Frame format: cmd, cnt, addr (ADDR_BYTES bytes, MSB first), then payload. Transfer length is cnt+1 (cnt=0 means 1 byte; cnt=255 means 256 bytes).
- Command codes:
  - 01 READ: no payload; replies with cnt+1 bytes.
  - 02 WRITE: cnt+1 data bytes follow; replies ACK_BYTE.
  - 03 FILL: one data byte follows; it is written to cnt+1 consecutive addresses; replies ACK_BYTE.
  - 04 CHECKSUM: no payload; replies with the 8-bit sum (mod 256) of cnt+1 bytes.
- In IDLE, any other received byte is ignored and the engine stays in IDLE.
- States:
  - IDLE -> RX_CNT on a valid cmd.
  - RX_CNT -> RX_ADDR.
  - RX_ADDR collects ADDR_BYTES bytes.
  - RX_ADDR then goes to: RD_ISSUE for READ, RX_DATA for WRITE or FILL, SUM for CHECKSUM.
  - The final FILL byte moves to FILL_RUN.
  - Remaining states: RD_ISSUE, RD_SEND, TX_HOLD, TX_WAIT, FILL_RUN, SUM, SUM_SEND, ACK.
- Memory: synchronous read with 1-cycle latency; write one byte per clock.
- Address wrap: addr+1 wraps from MEM_DEPTH-1 to 0. Address bits above log2(MEM_DEPTH) are discarded on entry.
- WRITE: each received data byte is written in the cycle after its strobe. Addr increments per byte. ACK is queued after byte cnt+1.
- FILL: one write per clock, cnt+1 clocks, then ACK. No UART bytes are accepted during FILL_RUN.
- READ:
  - RD_ISSUE waits for is_transmitting=0, then issues the read.
  - The next cycle, RD_SEND pulses transmit with the read data, then goes to TX_HOLD.
  - After the last byte, return to IDLE once the final TX_WAIT completes.
  - First transmit pulse occurs 2 clocks after the last address strobe if the UART is idle.
- CHECKSUM: accumulates one byte per clock. The sum is sent 1 clock after the last byte's read data returns.
- TX handshake:
  - transmit is high for exactly one clock.
  - TX_HOLD spends one clock unconditionally, covering the UART's is_transmitting rise latency.
  - TX_WAIT waits for is_transmitting=0 before any further transmit.
  - transmit is never asserted while is_transmitting=1.
- Timeout:
  - Applies in RX_CNT, RX_ADDR and RX_DATA only.
  - A counter resets on every received strobe.
  - When it reaches TIMEOUT_CYCLES: pulse timeout, go to IDLE, send no reply.
  - WRITE bytes already stored are kept.
- Overrun: a received strobe in RD_*, TX_*, FILL_RUN, SUM, SUM_SEND or ACK drops the byte and increments overrun_count, saturating at 255.
- Received strobe coinciding with a timeout expiry: the strobe wins, the counter resets and no timeout fires.
- Reset mid-operation: any in-flight transmit pulse is suppressed; a partially completed WRITE/FILL leaves earlier bytes stored.

Test Plan:
- WRITE 02 02 00 10 AA BB CC, then READ 01 02 00 10 -> ACK AA, then tx AA BB CC, each transmit only when is_transmitting=0.
- FILL 03 03 0F FE 5A with MEM_DEPTH=4096 -> addresses FFE, FFF, 000, 001 all hold 5A (wrap); single ACK AA.
- CHECKSUM 04 01 00 10 after the first scenario -> single tx byte 65 (AA+BB mod 256).
- Send 02 00, then hold quiet for TIMEOUT_CYCLES (set to 50 in the bench) -> timeout pulses once on cycle 50, busy drops, no tx. A subsequent valid READ works normally.
- READ with cnt=FF while injecting 3 extra received strobes -> 256 tx bytes sent, overrun_count=3. Bytes 00, 01, 02, 03, 05 in IDLE are ignored except the valid commands.
- Assert rst during the 2nd byte of a 4-byte READ -> transmit=0 immediately, busy=0, state IDLE. A fresh command after reset is processed correctly.
